// File: rtl/game_mm_pkg.sv
// Shared constants for the game register block: word addresses, CTRL and
// CMD_STAT bit positions, the default ID word and a byte-lane merge helper.
package game_mm_pkg;

    localparam logic [4:0] ADDR_ID           = 5'd0;
    localparam logic [4:0] ADDR_CTRL         = 5'd1;
    localparam logic [4:0] ADDR_BTN_LEVEL    = 5'd2;
    localparam logic [4:0] ADDR_BTN_EDGE     = 5'd3;
    localparam logic [4:0] ADDR_SCORE        = 5'd4;
    localparam logic [4:0] ADDR_TICK         = 5'd5;
    localparam logic [4:0] ADDR_CMD_PUSH     = 5'd6;
    localparam logic [4:0] ADDR_CMD_STAT     = 5'd7;
    localparam logic [4:0] ADDR_SCRATCH_BASE = 5'd8;

    localparam int CTRL_TICK_EN  = 0;
    localparam int CTRL_TICK_CLR = 1;
    localparam int CTRL_IRQ_LSB  = 8;
    localparam int CTRL_IRQ_MSB  = 12;

    localparam int STAT_FULL     = 8;
    localparam int STAT_EMPTY    = 9;
    localparam int STAT_OVERFLOW = 31;

    localparam logic [31:0] DEFAULT_ID_VALUE = 32'h47414D45;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = cur;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_cmd_fifo.sv
// First-word fall-through command FIFO; a pop on a full FIFO frees the slot
// for a same-cycle push, and a refused push is reported on overflow_set.
module game_cmd_fifo
    import game_mm_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [6:0]        level,
    output logic              full,
    output logic              empty,
    output logic              overflow_set
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [6:0]        count;
    logic              do_push;
    logic              do_pop;

    assign empty        = (count == 7'd0);
    assign full         = (count == 7'(FIFO_DEPTH));
    assign do_pop       = pop && !empty;
    assign do_push      = push && (!full || do_pop);
    assign overflow_set = push && full && !do_pop;
    assign head_data    = empty ? '0 : mem[rd_ptr];
    assign level        = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 7'd1;
                2'b01:   count <= count - 7'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/game_mm_responder.sv
// Avalon-MM register block for the game: ID, control, buttons, score, tick
// counter, scratch words and a command FIFO toward game logic.
module game_mm_responder
    import game_mm_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter int          TICK_DIV   = 50000,
    parameter logic [31:0] ID_VALUE   = DEFAULT_ID_VALUE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  avs_address,
    input  logic [3:0]  avs_byteenable,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    input  logic        avs_write,
    output logic [31:0] avs_readdata,
    input  logic [4:0]  btn_in,
    output logic [31:0] cmd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        irq
);

    localparam int PRE_W = $clog2(TICK_DIV);

    logic             wr_ctrl, wr_edge, wr_score, wr_push, wr_stat, wr_scratch;
    logic             tick_clr;
    logic             tick_en;
    logic [4:0]       irq_mask;
    logic [4:0]       btn_meta, btn_sync, btn_prev, btn_rise, btn_edge, edge_clr;
    logic [31:0]      score;
    logic [31:0]      tick;
    logic [PRE_W-1:0] prescale;
    logic [31:0]      scratch [8];
    logic             overflow, ovf_set, ovf_clr;
    logic [6:0]       fifo_level;
    logic             fifo_full, fifo_empty;
    logic [31:0]      rd_mux;

    assign wr_ctrl    = avs_write && (avs_address == ADDR_CTRL);
    assign wr_edge    = avs_write && (avs_address == ADDR_BTN_EDGE);
    assign wr_score   = avs_write && (avs_address == ADDR_SCORE);
    assign wr_push    = avs_write && (avs_address == ADDR_CMD_PUSH);
    assign wr_stat    = avs_write && (avs_address == ADDR_CMD_STAT);
    assign wr_scratch = avs_write && (avs_address[4:3] == ADDR_SCRATCH_BASE[4:3]);

    assign tick_clr = wr_ctrl && avs_byteenable[0] && avs_writedata[CTRL_TICK_CLR];
    assign edge_clr = (wr_edge && avs_byteenable[0]) ? avs_writedata[4:0] : 5'd0;
    assign ovf_clr  = wr_stat && avs_byteenable[3] && avs_writedata[STAT_OVERFLOW];
    assign btn_rise = btn_sync & ~btn_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_en  <= 1'b0;
            irq_mask <= '0;
        end else if (wr_ctrl) begin
            if (avs_byteenable[0]) begin
                tick_en <= avs_writedata[CTRL_TICK_EN];
            end
            if (avs_byteenable[1]) begin
                irq_mask <= avs_writedata[CTRL_IRQ_MSB:CTRL_IRQ_LSB];
            end
        end
    end

    // Two-flop synchroniser, then edge capture where a new edge beats a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta <= '0;
            btn_sync <= '0;
            btn_prev <= '0;
            btn_edge <= '0;
            irq      <= 1'b0;
        end else begin
            btn_meta <= btn_in;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
            btn_edge <= (btn_edge & ~edge_clr) | btn_rise;
            irq      <= |(btn_edge & irq_mask);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score <= '0;
            for (int i = 0; i < 8; i++) begin
                scratch[i] <= '0;
            end
        end else begin
            if (wr_score) begin
                score <= byte_merge(score, avs_writedata, avs_byteenable);
            end
            if (wr_scratch) begin
                scratch[avs_address[2:0]] <= byte_merge(scratch[avs_address[2:0]],
                                                        avs_writedata, avs_byteenable);
            end
        end
    end

    // A clear request wins over a terminal-count increment in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale <= '0;
            tick     <= '0;
        end else if (tick_clr) begin
            prescale <= '0;
            tick     <= '0;
        end else if (tick_en) begin
            if (prescale == PRE_W'(TICK_DIV - 1)) begin
                prescale <= '0;
                tick     <= tick + 32'd1;
            end else begin
                prescale <= prescale + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    game_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (32)
    ) u_cmd_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (wr_push),
        .push_data    (avs_writedata),
        .pop          (cmd_ready),
        .head_data    (cmd_data),
        .level        (fifo_level),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .overflow_set (ovf_set)
    );

    assign cmd_valid = !fifo_empty;

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_ID:        rd_mux = ID_VALUE;
            ADDR_CTRL: begin
                rd_mux[CTRL_TICK_EN]                = tick_en;
                rd_mux[CTRL_IRQ_MSB:CTRL_IRQ_LSB]   = irq_mask;
            end
            ADDR_BTN_LEVEL: rd_mux[4:0] = btn_sync;
            ADDR_BTN_EDGE:  rd_mux[4:0] = btn_edge;
            ADDR_SCORE:     rd_mux = score;
            ADDR_TICK:      rd_mux = tick;
            ADDR_CMD_STAT: begin
                rd_mux[6:0]           = fifo_level;
                rd_mux[STAT_FULL]     = fifo_full;
                rd_mux[STAT_EMPTY]    = fifo_empty;
                rd_mux[STAT_OVERFLOW] = overflow;
            end
            default: begin
                if (avs_address[4:3] == ADDR_SCRATCH_BASE[4:3]) begin
                    rd_mux = scratch[avs_address[2:0]];
                end
            end
        endcase
    end

    // Read data is captured from pre-write state and held until the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_game_mm_responder.sv
// Self-checking bench for game_mm_responder: directed register scenarios plus
// randomized bus traffic, compared every cycle against a behavioural model.
module tb_game_mm_responder;

    localparam int DEPTH = 4;
    localparam int TDIV  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  avs_address = '0;
    logic [3:0]  avs_byteenable = '0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_readdata;
    logic [4:0]  btn_in = '0;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    game_mm_responder #(
        .FIFO_DEPTH (DEPTH),
        .TICK_DIV   (TDIV),
        .ID_VALUE   (32'h47414D45)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .avs_address    (avs_address),
        .avs_byteenable (avs_byteenable),
        .avs_writedata  (avs_writedata),
        .avs_read       (avs_read),
        .avs_write      (avs_write),
        .avs_readdata   (avs_readdata),
        .btn_in         (btn_in),
        .cmd_data       (cmd_data),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model state: plain registers, a queue for the FIFO and a
    // three-deep history of sampled button values.
    logic [31:0] m_fifo [$];
    logic        m_en, m_ovf, m_irq;
    logic [4:0]  m_mask, m_edge, h1, h2, h3;
    logic [31:0] m_score, m_tick, m_rdata;
    int          m_pre;
    logic [31:0] m_scratch [8];

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] r;
        int lvl;
        r   = 32'd0;
        lvl = m_fifo.size();
        case (a)
            5'd0: r = 32'h47414D45;
            5'd1: r = {19'd0, m_mask, 7'd0, m_en};
            5'd2: r = {27'd0, h2};
            5'd3: r = {27'd0, m_edge};
            5'd4: r = m_score;
            5'd5: r = m_tick;
            5'd7: r = {m_ovf, 21'd0, (lvl == 0), (lvl == DEPTH), 1'b0, 7'(lvl)};
            default: if (a >= 5'd8 && a <= 5'd15) r = m_scratch[a[2:0]];
        endcase
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_fifo.delete();
            m_en = 0; m_ovf = 0; m_irq = 0; m_mask = 0; m_edge = 0;
            h1 = 0; h2 = 0; h3 = 0; m_score = 0; m_tick = 0; m_rdata = 0; m_pre = 0;
            for (int i = 0; i < 8; i++) m_scratch[i] = 0;
        end else begin
            logic       nirq, tclr, oset, oclr;
            logic [4:0] eclr, rise;
            nirq = |(m_edge & m_mask);
            if (avs_read) m_rdata = model_read(avs_address);
            if (cmd_ready && m_fifo.size() > 0) void'(m_fifo.pop_front());
            oset = 0;
            if (avs_write && avs_address == 5'd6) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(avs_writedata);
                else oset = 1;
            end
            tclr = avs_write && avs_address == 5'd1 && avs_byteenable[0] && avs_writedata[1];
            eclr = (avs_write && avs_address == 5'd3 && avs_byteenable[0]) ? avs_writedata[4:0] : 5'd0;
            oclr = avs_write && avs_address == 5'd7 && avs_byteenable[3] && avs_writedata[31];
            if (tclr) begin
                m_tick = 0; m_pre = 0;
            end else if (m_en) begin
                m_pre = m_pre + 1;
                if (m_pre == TDIV) begin
                    m_pre = 0; m_tick = m_tick + 1;
                end
            end
            if (avs_write) begin
                if (avs_address == 5'd1) begin
                    if (avs_byteenable[0]) m_en = avs_writedata[0];
                    if (avs_byteenable[1]) m_mask = avs_writedata[12:8];
                end
                if (avs_address == 5'd4) m_score = merge(m_score, avs_writedata, avs_byteenable);
                if (avs_address >= 5'd8 && avs_address <= 5'd15)
                    m_scratch[avs_address[2:0]] = merge(m_scratch[avs_address[2:0]], avs_writedata, avs_byteenable);
            end
            rise   = h2 & ~h3;
            m_edge = (m_edge & ~eclr) | rise;
            h3 = h2; h2 = h1; h1 = btn_in;
            m_ovf = (m_ovf & ~oclr) | oset;
            m_irq = nirq;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    endtask

    task automatic checkRange(input string name, input logic [31:0] actual,
                              input logic [31:0] lo, input logic [31:0] hi);
        n_checks++;
        if (actual >= lo && actual <= hi) n_pass++;
        else $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
    endtask

    // Every cycle outside reset, the DUT outputs must equal the model.
    always @(negedge clk) begin
        if (check_en && !reset) begin
            checkOutput("model_cmd_valid", {31'd0, cmd_valid}, {31'd0, m_fifo.size() != 0});
            checkOutput("model_cmd_data", cmd_data, (m_fifo.size() != 0) ? m_fifo[0] : 32'd0);
            checkOutput("model_irq", {31'd0, irq}, {31'd0, m_irq});
            checkOutput("model_readdata", avs_readdata, m_rdata);
        end
    end

    // One bus cycle, starting and ending just after a falling edge.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [4:0] addr,
                                 input logic [3:0] be, input logic [31:0] data,
                                 output logic [31:0] rdata);
        avs_read       = rd;
        avs_write      = wr;
        avs_address    = addr;
        avs_byteenable = be;
        avs_writedata  = data;
        @(posedge clk);
        @(negedge clk);
        rdata     = avs_readdata;
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic busWrite(input logic [4:0] addr, input logic [3:0] be, input logic [31:0] data);
        logic [31:0] unused_rd;
        applyStimulus(1'b0, 1'b1, addr, be, data, unused_rd);
    endtask

    task automatic busRead(input logic [4:0] addr, output logic [31:0] data);
        applyStimulus(1'b1, 1'b0, addr, 4'h0, 32'd0, data);
    endtask

    task automatic readCheck(input string name, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        busRead(addr, d);
        checkOutput(name, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        int          cnt;
        int          r;

        repeat (3) @(negedge clk);
        reset    = 1'b0;
        check_en = 1'b1;

        readCheck("id", 5'd0, 32'h47414D45);
        readCheck("ctrl_reset", 5'd1, 32'd0);
        readCheck("edge_reset", 5'd3, 32'd0);
        readCheck("score_reset", 5'd4, 32'd0);
        readCheck("tick_reset", 5'd5, 32'd0);
        readCheck("stat_reset", 5'd7, 32'h00000200);

        busWrite(5'd4, 4'b0101, 32'hAABBCCDD);
        readCheck("score_be0101", 5'd4, 32'h00BB00DD);
        busWrite(5'd4, 4'b1111, 32'h11223344);
        readCheck("score_full", 5'd4, 32'h11223344);
        busWrite(5'd9, 4'b1100, 32'hDEADBEEF);
        readCheck("scratch1_be1100", 5'd9, 32'hDEAD0000);
        readCheck("unmapped_20", 5'd20, 32'd0);

        busWrite(5'd1, 4'hF, 32'h00000400);
        btn_in[2] = 1'b1;
        cnt = 9;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (irq) begin
                cnt = i;
                break;
            end
        end
        checkRange("irq_latency", cnt, 1, 4);
        repeat (6) @(negedge clk);
        readCheck("btn_level", 5'd2, 32'h04);
        readCheck("btn_edge", 5'd3, 32'h04);
        busWrite(5'd3, 4'h1, 32'h04);
        readCheck("btn_edge_clr", 5'd3, 32'd0);
        checkOutput("irq_dropped", {31'd0, irq}, 32'd0);

        btn_in[2] = 1'b0;
        repeat (5) @(negedge clk);
        btn_in[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        busWrite(5'd3, 4'h1, 32'h04);
        readCheck("edge_set_wins", 5'd3, 32'h04);

        busWrite(5'd1, 4'hF, 32'h1);
        repeat (40) @(negedge clk);
        busRead(5'd5, d);
        checkRange("tick_count", d, 9, 11);
        busWrite(5'd1, 4'hF, 32'h3);
        busRead(5'd5, d);
        checkRange("tick_cleared", d, 0, 1);
        busWrite(5'd1, 4'hF, 32'h0);

        cmd_ready = 1'b0;
        for (int i = 1; i <= 5; i++) busWrite(5'd6, 4'h0, 32'(i));
        readCheck("stat_full_ovf", 5'd7, 32'h80000104);
        cmd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checkOutput("pop_valid", {31'd0, cmd_valid}, 32'd1);
            checkOutput("pop_data", cmd_data, 32'(i));
            @(negedge clk);
        end
        checkOutput("drained_valid", {31'd0, cmd_valid}, 32'd0);
        cmd_ready = 1'b0;
        busWrite(5'd7, 4'hF, 32'h80000000);
        readCheck("ovf_cleared", 5'd7, 32'h00000200);

        for (int i = 0; i < 4; i++) busWrite(5'd6, 4'hF, 32'h10 + 32'(i));
        cmd_ready = 1'b1;
        busWrite(5'd6, 4'hF, 32'h14);
        cmd_ready = 1'b0;
        readCheck("full_push_pop", 5'd7, 32'h00000104);
        checkOutput("head_after_pp", cmd_data, 32'h11);

        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_rst_valid", {31'd0, cmd_valid}, 32'd0);
        checkOutput("async_rst_data", cmd_data, 32'd0);
        checkOutput("async_rst_rdata", avs_readdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        readCheck("stat_after_rst", 5'd7, 32'h00000200);
        readCheck("score_after_rst", 5'd4, 32'd0);

        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 11);
            avs_address    = (r < 9) ? 5'(r) : 5'($urandom_range(0, 31));
            avs_read       = ($urandom_range(0, 2) == 0);
            avs_write      = ($urandom_range(0, 2) == 0);
            avs_byteenable = 4'($urandom);
            avs_writedata  = $urandom;
            if (avs_address == 5'd1 && $urandom_range(0, 7) != 0) avs_writedata[1] = 1'b0;
            if ($urandom_range(0, 7) == 0) btn_in = 5'($urandom);
            cmd_ready = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        avs_read  = 1'b0;
        avs_write = 1'b0;
        cmd_ready = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
